// File: rtl/cbus_sram_responder_if.sv
// rtl/cbus_sram_responder_if.sv - cbus request/response bundle between a cache-side initiator and the memory responder
interface cbus_sram_responder_if;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);

endinterface

// File: rtl/cbus_sram_responder.sv
// rtl/cbus_sram_responder.sv - cbus memory endpoint: word array serving single/burst reads and writes
// with programmable first-beat latency and optional one-cycle gaps between beats.
module cbus_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int BEAT_GAP   = 0
) (
  input  logic                        clk,
  input  logic                        resetn,
  cbus_sram_responder_if.slave        cbus,
  output logic                        busy,
  output logic [31:0]                 txn_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_TURN} state_t;

  state_t                state, state_d;
  logic [3:0]            lat, lat_d;
  logic [3:0]            beat, beat_d;
  logic                  gap, gap_d;
  logic                  accept;
  logic [3:0]            len_q;
  logic                  is_write_q;
  logic [ADDR_WIDTH-1:0] base_idx;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  beat_fire;
  logic                  last_beat;
  logic [31:0]           rd_data;
  logic [31:0]           mem [DEPTH];

  assign idx = base_idx + ADDR_WIDTH'(beat);

  // A beat only fires while the initiator still holds valid, so an abort never shows ready.
  assign beat_fire = (state == S_BURST) && !gap && cbus.creq.valid;
  assign last_beat = beat_fire && (beat == len_q);

  always_comb begin
    state_d = state;
    lat_d   = lat;
    beat_d  = beat;
    gap_d   = gap;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cbus.creq.valid) begin
          accept  = 1'b1;
          beat_d  = 4'd0;
          gap_d   = 1'b0;
          lat_d   = 4'(LATENCY);
          state_d = (LATENCY > 0) ? S_WAIT : S_BURST;
        end
      end
      S_WAIT: begin
        if (!cbus.creq.valid) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat - 4'd1;
          if (lat == 4'd1) state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (!cbus.creq.valid) begin
          state_d = S_IDLE;
        end else if (gap) begin
          gap_d = 1'b0;
        end else begin
          beat_d = beat + 4'd1;
          gap_d  = (BEAT_GAP != 0);
          if (beat == len_q) state_d = S_TURN;
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      lat        <= 4'd0;
      beat       <= 4'd0;
      gap        <= 1'b0;
      len_q      <= 4'd0;
      is_write_q <= 1'b0;
      base_idx   <= '0;
      txn_count  <= 32'd0;
    end else begin
      state <= state_d;
      lat   <= lat_d;
      beat  <= beat_d;
      gap   <= gap_d;
      if (accept) begin
        len_q      <= cbus.creq.len;
        is_write_q <= cbus.creq.is_write;
        base_idx   <= cbus.creq.addr[ADDR_WIDTH+1:2];
      end
      if (last_beat) txn_count <= txn_count + 32'd1;
    end
  end

  // Array is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (resetn && beat_fire && is_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (cbus.creq.strobe[i]) mem[idx][8*i +: 8] <= cbus.creq.data[8*i +: 8];
      end
    end
  end

  assign rd_data    = (beat_fire && !is_write_q) ? mem[idx] : 32'd0;
  assign cbus.cresp = {beat_fire, last_beat, rd_data};
  assign busy       = (state != S_IDLE);

  logic unused_req;
  assign unused_req = ^{cbus.creq.size, cbus.creq.addr[31:ADDR_WIDTH+2], cbus.creq.addr[1:0]};

endmodule

// File: tb/tb_cbus_sram_responder.sv
// tb/tb_cbus_sram_responder.sv - randomized bench for cbus_sram_responder against a transaction-level memory model
module tb_cbus_sram_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int LAT_A = 2;
  localparam int GAP_A = 0;
  localparam int LAT_B = 1;
  localparam int GAP_B = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sel;
  logic        req_valid, req_is_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_strobe, req_len;
  logic        busy_a, busy_b;
  logic [31:0] tc_a, tc_b;

  cbus_sram_responder_if ifa ();
  cbus_sram_responder_if ifb ();

  assign ifa.creq = {req_valid & ~sel, req_is_write, req_size, req_addr, req_strobe, req_data, req_len};
  assign ifb.creq = {req_valid & sel,  req_is_write, req_size, req_addr, req_strobe, req_data, req_len};

  cbus_sram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_A), .BEAT_GAP(GAP_A)) dut_a (
    .clk(clk), .resetn(resetn), .cbus(ifa.slave), .busy(busy_a), .txn_count(tc_a));
  cbus_sram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_B), .BEAT_GAP(GAP_B)) dut_b (
    .clk(clk), .resetn(resetn), .cbus(ifb.slave), .busy(busy_b), .txn_count(tc_b));

  always #5 clk = ~clk;

  logic        ready_m, last_m, busy_m;
  logic [31:0] data_m, tc_m;
  assign ready_m = sel ? ifb.cresp.ready : ifa.cresp.ready;
  assign last_m  = sel ? ifb.cresp.last  : ifa.cresp.last;
  assign data_m  = sel ? ifb.cresp.data  : ifa.cresp.data;
  assign busy_m  = sel ? busy_b : busy_a;
  assign tc_m    = sel ? tc_b : tc_a;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] ref_mem   [2][DEPTH];
  logic [3:0]  ref_known [2][DEPTH];
  logic [31:0] cnt [2];
  logic [31:0] wq[$];
  bit          rand_strobe;
  logic [3:0]  strobe_fix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic model_write(input bit s, input int idx, input logic [31:0] d, input logic [3:0] st);
    for (int i = 0; i < 4; i++) begin
      if (st[i]) begin
        ref_mem[s][idx][8*i +: 8] = d[8*i +: 8];
        ref_known[s][idx][i] = 1'b1;
      end
    end
  endtask

  task automatic next_beat_inputs();
    req_data   = (wq.size() > 0) ? wq.pop_front() : $urandom;
    req_strobe = rand_strobe ? 4'($urandom_range(0, 15)) : strobe_fix;
  endtask

  // One transaction; expected ready cycles follow from latency and gap: beat k at LAT+1+k*(1+GAP).
  task automatic run_txn(input bit s, input bit w, input logic [31:0] a, input int len,
                         input int abort_at, input bit hold_after, input bit b2b);
    int k, c, nxt, lat, gp, idx;
    logic [31:0] m;
    lat = s ? LAT_B : LAT_A;
    gp  = s ? GAP_B : GAP_A;
    if (!b2b) begin @(posedge clk); #1; end
    sel = s; req_is_write = w; req_addr = a; req_len = 4'(len);
    req_size = 2'($urandom_range(0, 3));
    next_beat_inputs();
    req_valid = 1'b1;
    if (b2b) begin
      @(negedge clk);
      check("turn_ready", 32'(ready_m), 32'd0);
      check("turn_busy", 32'(busy_m), 32'd1);
      @(posedge clk); #1;
    end
    k = 0; c = 0; nxt = lat + 1;
    while (1) begin
      @(negedge clk);
      check("ready", 32'(ready_m), 32'(c == nxt));
      check("busy", 32'(busy_m), 32'(c != 0));
      if (c == nxt) begin
        idx = int'(((a >> 2) + 32'(k)) & 32'(DEPTH - 1));
        check("last", 32'(last_m), 32'(k == len));
        if (w) begin
          check("wr_resp_data", data_m, 32'd0);
          model_write(s, idx, req_data, req_strobe);
        end else begin
          m = lane_mask(ref_known[s][idx]);
          check("rd_data", data_m & m, ref_mem[s][idx] & m);
        end
        k++;
        nxt += 1 + gp;
      end else begin
        check("idle_data", data_m, 32'd0);
      end
      @(posedge clk); #1;
      if (k > len) begin
        if (!hold_after) req_valid = 1'b0;
        cnt[s]++;
        check("txn_count", tc_m, cnt[s]);
        break;
      end
      if (k == abort_at) begin
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready_m), 32'd0);
        @(posedge clk); #1;
        check("abort_busy", 32'(busy_m), 32'd0);
        check("abort_count", tc_m, cnt[s]);
        break;
      end
      if (c >= 60) begin
        check("timeout_beats", 32'(k), 32'(len + 1));
        req_valid = 1'b0;
        break;
      end
      c++;
      next_beat_inputs();
    end
  endtask

  initial begin
    int  k;
    bit  s, w, hold, prev_hold;
    int  len, ab;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) begin
      ref_known[0][i] = 4'h0; ref_known[1][i] = 4'h0;
      ref_mem[0][i] = 32'd0;  ref_mem[1][i] = 32'd0;
    end
    cnt[0] = 0; cnt[1] = 0;
    rand_strobe = 1'b0; strobe_fix = 4'hF;
    resetn = 1'b0; sel = 1'b0; req_valid = 1'b0; req_is_write = 1'b0; req_size = 2'd0;
    req_addr = 32'd0; req_data = 32'd0; req_strobe = 4'd0; req_len = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ifa.cresp.ready), 32'd0);
    check("rst_last", 32'(ifa.cresp.last), 32'd0);
    check("rst_data", ifa.cresp.data, 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_count_a", tc_a, 32'd0);
    check("rst_count_b", tc_b, 32'd0);
    resetn = 1'b1;

    wq.push_back(32'hDEADBEEF);
    run_txn(0, 1, 32'h100, 0, -1, 0, 0);
    run_txn(0, 0, 32'h100, 0, -1, 0, 0);

    wq = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_txn(0, 1, 32'h40, 3, -1, 0, 0);
    run_txn(0, 0, 32'h40, 3, -1, 0, 0);

    wq.push_back(32'hAABBCCDD);
    run_txn(0, 1, 32'h8, 0, -1, 0, 0);
    strobe_fix = 4'h1;
    wq.push_back(32'h00000011);
    run_txn(0, 1, 32'h8, 0, -1, 0, 0);
    strobe_fix = 4'hF;
    run_txn(0, 0, 32'h8, 0, -1, 0, 0);

    run_txn(1, 1, 32'h40, 3, -1, 0, 0);
    run_txn(1, 0, 32'h40, 3, -1, 0, 0);
    run_txn(0, 1, 32'hFF8, 3, -1, 0, 0);
    run_txn(0, 0, 32'hFF8, 3, -1, 0, 0);

    run_txn(0, 1, 32'h300, 3, -1, 0, 0);
    run_txn(0, 1, 32'h300, 3, 2, 0, 0);
    run_txn(0, 0, 32'h300, 3, -1, 0, 0);

    run_txn(0, 1, 32'h200, 3, -1, 0, 0);
    @(posedge clk); #1;
    sel = 1'b0; req_is_write = 1'b1; req_addr = 32'h200; req_len = 4'd15;
    req_strobe = 4'hF; req_data = $urandom; req_valid = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      @(negedge clk);
      if (ready_m) begin
        model_write(0, 32'h80 + k, req_data, req_strobe);
        k++;
      end
      @(posedge clk); #1;
      req_data = $urandom;
    end
    check("rst_mid_beats", 32'(k), 32'd2);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; req_valid = 1'b0;
    cnt[0] = 0; cnt[1] = 0;
    @(negedge clk);
    check("rst_mid_ready", 32'(ifa.cresp.ready), 32'd0);
    check("rst_mid_busy", 32'(busy_a), 32'd0);
    check("rst_mid_count", tc_a, 32'd0);
    run_txn(0, 0, 32'h200, 3, -1, 0, 0);

    run_txn(0, 1, 32'h500, 3, -1, 1, 0);
    run_txn(0, 0, 32'h500, 3, -1, 0, 1);

    rand_strobe = 1'b1;
    prev_hold = 1'b0;
    s = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if (!prev_hold) s = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      a   = $urandom;
      len = (it % 3 == 0) ? 0 : int'($urandom_range(0, 15));
      ab  = -1;
      if (!prev_hold && len > 0 && $urandom_range(0, 5) == 0) ab = int'($urandom_range(0, len));
      hold = (ab < 0) && ($urandom_range(0, 3) == 0);
      run_txn(s, w, a, len, ab, hold, prev_hold);
      prev_hold = hold;
    end
    if (prev_hold) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
